// File: rtl/uart_block_loader.sv
// uart_block_loader: frames UART receiver bytes into 512-bit SHA-256 blocks.
// A header byte opens a block; 64 payload bytes are packed big-endian into
// 16 x 32-bit words, which are then streamed out over a valid/ready handshake.
//
// Ports:
//   CLK, RST_N        clock (rising edge), asynchronous active-low reset
//   Rx_DV_in          1-cycle byte-valid strobe from the UART receiver
//   Rx_Byte_in        received byte, qualified by Rx_DV_in
//   Word_out          message word (zero while Word_valid_out is low)
//   Word_valid_out    Word_out holds a word for the SHA core
//   Word_ready_in     SHA core accepts the presented word
//   Word_last_out     presented word is the final word of the block
//   Block_done_out    1-cycle pulse after the final word transferred
//   Timeout_err_out   1-cycle pulse when a partial block is abandoned
//   Overrun_out       1-cycle pulse when a byte is dropped while sending
//   Busy_out          a block is being collected or sent
module uart_block_loader #(
    parameter logic [7:0] HEADER_BYTE     = 8'hA5,
    parameter int         WORDS_PER_BLOCK = 16,
    parameter int         TIMEOUT_CYCLES  = 8680
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        Rx_DV_in,
    input  logic [7:0]  Rx_Byte_in,
    output logic [31:0] Word_out,
    output logic        Word_valid_out,
    input  logic        Word_ready_in,
    output logic        Word_last_out,
    output logic        Block_done_out,
    output logic        Timeout_err_out,
    output logic        Overrun_out,
    output logic        Busy_out
);

    localparam int NBYTES = 4 * WORDS_PER_BLOCK;
    localparam int BW     = $clog2(NBYTES);
    localparam int WW     = $clog2(WORDS_PER_BLOCK);
    localparam int TW     = $clog2(TIMEOUT_CYCLES);

    localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);
    localparam logic [WW-1:0] LAST_WORD = WW'(WORDS_PER_BLOCK - 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_SEND
    } state_t;

    state_t        state;
    logic [BW-1:0] byte_cnt;
    logic [WW-1:0] word_idx;
    logic [TW-1:0] timer;
    logic [31:0]   words [WORDS_PER_BLOCK];

    // Word index of the byte being written; low two bits pick the lane.
    logic [WW-1:0] wsel;
    assign wsel = byte_cnt[BW-1:2];

    // Both are selected from registers only; gating keeps the bus quiet
    // whenever nothing is offered.
    assign Word_out      = Word_valid_out ? words[word_idx] : 32'd0;
    assign Word_last_out = Word_valid_out && (word_idx == LAST_WORD);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state           <= S_IDLE;
            byte_cnt        <= '0;
            word_idx        <= '0;
            timer           <= '0;
            Word_valid_out  <= 1'b0;
            Block_done_out  <= 1'b0;
            Timeout_err_out <= 1'b0;
            Overrun_out     <= 1'b0;
            Busy_out        <= 1'b0;
            for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                words[i] <= 32'd0;
            end
        end else begin
            Block_done_out  <= 1'b0;
            Timeout_err_out <= 1'b0;
            Overrun_out     <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (Rx_DV_in && (Rx_Byte_in == HEADER_BYTE)) begin
                        state    <= S_COLLECT;
                        byte_cnt <= '0;
                        timer    <= '0;
                        Busy_out <= 1'b1;
                    end
                end

                S_COLLECT: begin
                    if (Rx_DV_in) begin
                        // Header-valued bytes are ordinary data here.
                        unique case (byte_cnt[1:0])
                            2'd0: words[wsel][31:24] <= Rx_Byte_in;
                            2'd1: words[wsel][23:16] <= Rx_Byte_in;
                            2'd2: words[wsel][15:8]  <= Rx_Byte_in;
                            default: words[wsel][7:0] <= Rx_Byte_in;
                        endcase
                        timer <= '0;
                        if (byte_cnt == LAST_BYTE) begin
                            state          <= S_SEND;
                            word_idx       <= '0;
                            Word_valid_out <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end else if (timer == TIMER_MAX) begin
                        // Partial block is abandoned; the next block
                        // rewrites every byte, so no stale data survives.
                        Timeout_err_out <= 1'b1;
                        state           <= S_IDLE;
                        Busy_out        <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_SEND: begin
                    if (Rx_DV_in) begin
                        Overrun_out <= 1'b1;
                    end
                    if (Word_ready_in) begin
                        if (word_idx == LAST_WORD) begin
                            Block_done_out <= 1'b1;
                            Word_valid_out <= 1'b0;
                            Busy_out       <= 1'b0;
                            word_idx       <= '0;
                            state          <= S_IDLE;
                        end else begin
                            word_idx <= word_idx + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_block_loader.sv
// tb_uart_block_loader: directed stimulus with a queue scoreboard; a
// separate monitor pops expected words whenever a word transfers.
module tb_uart_block_loader;

    localparam int T = 8680;

    logic        CLK;
    logic        RST_N;
    logic        Rx_DV_in;
    logic [7:0]  Rx_Byte_in;
    logic [31:0] Word_out;
    logic        Word_valid_out;
    logic        Word_ready_in;
    logic        Word_last_out;
    logic        Block_done_out;
    logic        Timeout_err_out;
    logic        Overrun_out;
    logic        Busy_out;

    uart_block_loader #(
        .HEADER_BYTE    (8'hA5),
        .WORDS_PER_BLOCK(16),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .Rx_DV_in       (Rx_DV_in),
        .Rx_Byte_in     (Rx_Byte_in),
        .Word_out       (Word_out),
        .Word_valid_out (Word_valid_out),
        .Word_ready_in  (Word_ready_in),
        .Word_last_out  (Word_last_out),
        .Block_done_out (Block_done_out),
        .Timeout_err_out(Timeout_err_out),
        .Overrun_out    (Overrun_out),
        .Busy_out       (Busy_out)
    );

    typedef struct packed {
        logic [31:0] w;
        logic        l;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          checks;
    int          failures;
    int          done_cnt;
    int          to_cnt;
    int          ov_cnt;
    int          words_seen;
    int          blk_pos;
    int          rdy_mode;
    int          exp_done;
    int          base;
    logic        stall;
    logic [31:0] pw;
    logic        pl;
    logic [7:0]  blk [64];
    logic [31:0] got_words [16];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Ready generator: 0 = held high, 1 = toggling, 2 = held low.
    initial begin
        Word_ready_in = 1'b1;
        forever begin
            @(negedge CLK);
            case (rdy_mode)
                0: Word_ready_in = 1'b1;
                1: Word_ready_in = ~Word_ready_in;
                default: Word_ready_in = 1'b0;
            endcase
        end
    end

    // Monitor samples just before each rising edge, after inputs settle.
    initial begin
        stall   = 1'b0;
        blk_pos = 0;
        forever begin
            @(negedge CLK);
            #4;
            if (!RST_N) begin
                stall   = 1'b0;
                blk_pos = 0;
                continue;
            end
            if (Block_done_out) done_cnt++;
            if (Timeout_err_out) to_cnt++;
            if (Overrun_out) ov_cnt++;
            if (stall && Word_valid_out) begin
                check("stall_word", Word_out, pw);
                check("stall_last", Word_last_out, pl);
            end
            if (Word_valid_out && Word_ready_in) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got %h expected none",
                             Word_out);
                end else begin
                    e = exp_q.pop_front();
                    check("word", Word_out, e.w);
                    check("last", Word_last_out, e.l);
                    got_words[blk_pos] = Word_out;
                    blk_pos = e.l ? 0 : blk_pos + 1;
                    words_seen++;
                end
            end
            stall = Word_valid_out && !Word_ready_in;
            pw    = Word_out;
            pl    = Word_last_out;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        Rx_DV_in   = 1'b1;
        Rx_Byte_in = b;
        @(negedge CLK);
        Rx_DV_in   = 1'b0;
        Rx_Byte_in = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic fill_seq(input logic [7:0] b0);
        for (int i = 0; i < 64; i++) blk[i] = b0 + 8'(i);
    endtask

    task automatic push_exp();
        for (int w = 0; w < 16; w++) begin
            exp_q.push_back({blk[4*w], blk[4*w+1], blk[4*w+2], blk[4*w+3],
                             (w == 15)});
        end
    endtask

    task automatic send_block();
        send_byte(8'hA5);
        push_exp();
        for (int i = 0; i < 64; i++) send_byte(blk[i]);
    endtask

    task automatic wait_done(input int budget);
        exp_done++;
        for (int i = 0; i < budget && done_cnt < exp_done; i++) begin
            @(negedge CLK);
        end
        idle(2);
        check("done_count", done_cnt, exp_done);
        check("queue_empty", exp_q.size(), 0);
    endtask

    task automatic check_zero(input string name);
        check(name, {Word_out, Word_valid_out, Word_last_out, Block_done_out,
                     Timeout_err_out, Overrun_out, Busy_out}, 64'd0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        done_cnt   = 0;
        to_cnt     = 0;
        ov_cnt     = 0;
        words_seen = 0;
        exp_done   = 0;
        rdy_mode   = 0;
        RST_N      = 1'b0;
        Rx_DV_in   = 1'b0;
        Rx_Byte_in = 8'h00;
        idle(3);
        #1;
        check_zero("reset_outputs");
        @(negedge CLK);
        RST_N = 1'b1;
        idle(2);

        // T1: incrementing block, ready held high.
        fill_seq(8'h00);
        send_block();
        #1;
        check("t1_valid_latency", Word_valid_out, 1'b1);
        check("t1_first_word", Word_out, 32'h00010203);
        @(negedge CLK);
        wait_done(40);
        check("t1_w0", got_words[0], 32'h00010203);
        check("t1_w1", got_words[1], 32'h04050607);
        check("t1_w15", got_words[15], 32'h3C3D3E3F);
        check("t1_idle_busy", Busy_out, 1'b0);

        // T2: same block with ready toggling.
        rdy_mode = 1;
        send_block();
        wait_done(80);
        check("t2_w15", got_words[15], 32'h3C3D3E3F);
        rdy_mode = 0;
        idle(2);

        // T3: timeout after 10 bytes, then a byte exactly at the threshold.
        send_byte(8'hA5);
        for (int i = 0; i < 10; i++) send_byte(8'hEE);
        idle(T + 2);
        check("t3_timeout_pulse", to_cnt, 1);
        check("t3_busy_after_timeout", Busy_out, 1'b0);
        fill_seq(8'h40);
        send_byte(8'hA5);
        push_exp();
        send_byte(blk[0]);
        idle(T - 1);
        for (int i = 1; i < 64; i++) send_byte(blk[i]);
        wait_done(40);
        check("t3_no_timeout_at_threshold", to_cnt, 1);
        check("t3_w0", got_words[0], 32'h40414243);
        check("t3_w15", got_words[15], 32'h7C7D7E7F);

        // T4: junk before header, header value inside payload.
        send_byte(8'h11);
        send_byte(8'h22);
        idle(2);
        check("t4_junk_ignored", Busy_out, 1'b0);
        fill_seq(8'h00);
        blk[5] = 8'hA5;
        send_block();
        wait_done(40);
        check("t4_w0", got_words[0], 32'h00010203);
        check("t4_w1", got_words[1], 32'h04A50607);

        // T5: bytes arriving while stalled in send are dropped.
        rdy_mode = 2;
        idle(1);
        fill_seq(8'h80);
        send_block();
        idle(2);
        send_byte(8'h77);
        idle(1);
        send_byte(8'hA5);
        idle(2);
        check("t5_overrun_pulses", ov_cnt, 2);
        check("t5_still_valid", Word_valid_out, 1'b1);
        check("t5_held_word", Word_out, 32'h80818283);
        rdy_mode = 0;
        wait_done(40);
        check("t5_w15", got_words[15], 32'hBCBDBEBF);
        fill_seq(8'hC0);
        send_block();
        wait_done(40);
        check("t5_next_w0", got_words[0], 32'hC0C1C2C3);
        check("t5_overrun_total", ov_cnt, 2);

        // T6: reset during collection and during send.
        fill_seq(8'h00);
        send_byte(8'hA5);
        for (int i = 0; i < 30; i++) send_byte(blk[i]);
        RST_N = 1'b0;
        #1;
        check_zero("t6_reset_collect");
        idle(2);
        RST_N = 1'b1;
        idle(1);
        base = words_seen;
        send_block();
        for (int i = 0; i < 40 && words_seen < base + 7; i++) begin
            @(negedge CLK);
        end
        check("t6_reached_word7", words_seen - base, 7);
        RST_N = 1'b0;
        #1;
        check_zero("t6_reset_send");
        exp_q.delete();
        idle(2);
        RST_N = 1'b1;
        idle(2);
        check("t6_no_done", done_cnt, exp_done);
        check("t6_no_timeout", to_cnt, 1);
        fill_seq(8'h10);
        send_block();
        wait_done(40);
        check("t6_w0", got_words[0], 32'h10111213);
        check("t6_w3", got_words[3], 32'h1C1D1E1F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
